config_loader: RTL and testbench
================================

# config_loader

Sequencing controller for the tile configuration latch bank. It accepts a framed word stream over a valid/ready handshake and drives the bank's shared 32-bit data bus and one-hot word enables with a setup/strobe/hold sequence, so that every transparent latch captures stable data. It supports full or partial reconfiguration, because each frame names a start word and a word count. It sits between the bitstream source (scan/host interface) and the latch bank in each tile.

## Interface
- NUM_WORDS, 30, number of 32-bit config words in the latch bank (enable width)
- WORD_W, 32, config data width
- STROBE_CYCLES, 1, cycles each enable is held high (≥1)
- IDX_W, $clog2(NUM_WORDS), derived; word index width (5 at default)
- clk  input  1  sole clock
- reset  input  1  synchronous, active-high
- io_cfg_valid  input  1  upstream word valid
- io_cfg_data  input  WORD_W  upstream word (header or payload)
- io_cfg_ready  output  1  controller accepts word this cycle
- io_d_in  output  WORD_W  shared data bus to latch bank, registered
- io_configs_en  output  NUM_WORDS  one-hot latch enables, registered, glitch-free
- io_busy  output  1  frame in progress (any state but IDLE)
- io_done  output  1  one-cycle pulse after last word of a frame is held
- io_err  output  1  sticky: last header was out of range; cleared by next accepted header

## Operation
- Frame = 1 header word + N payload words. Header: bits [IDX_W-1:0] = start index S; bits [2*IDX_W-1:IDX_W] = count-1 field C; N = C+1 (1..2^IDX_W). All other bits are ignored.
- Range check: S+N > NUM_WORDS, computed in IDX_W+1 bits → io_err=1, frame rejected, no enables fired, state stays IDLE; following words are treated as headers.
- States: IDLE (ready=1, waits for header) → LOAD (ready=1, waits for payload) → SETUP → STROBE → HOLD → LOAD while remaining>0, else DONE → IDLE.
- The accepted payload word is registered into io_d_in; the target index starts at S and increments by 1 after each HOLD; the remaining count decrements after each HOLD.
- SETUP: io_d_in = word, io_configs_en = 0. STROBE: io_configs_en = 1<<idx for STROBE_CYCLES cycles, io_d_in unchanged. HOLD: io_configs_en = 0, io_d_in unchanged.
- io_d_in changes only on a LOAD accept; at no cycle is more than one enable bit high.
- io_cfg_ready=0 in SETUP, STROBE, HOLD, and DONE. The valid/ready rule: a word transfers on a valid&&ready edge. Upstream holds data stable while valid && !ready.
- The controller never drops valid or payload words; with no valid data in LOAD it waits indefinitely.

## Timing
- Reset values: io_d_in=0, io_configs_en=0, io_cfg_ready=0, io_busy=0, io_done=0, io_err=0, state=IDLE. io_cfg_ready rises in the first cycle after reset deasserts.
- Header accepted at edge T → LOAD at T+1.
- Payload accepted at edge P → SETUP in cycle P+1, STROBE in P+2..P+1+STROBE_CYCLES, HOLD in the next cycle, then LOAD or DONE. Throughput is 3+STROBE_CYCLES cycles per word when upstream keeps valid high.
- io_done is high for exactly the one cycle after the final HOLD. io_busy falls together with the return to IDLE.
- Reset asserted mid-frame: all outputs return to reset values at the next edge, and any enable drops there. Words already written stay in the bank (no rollback). The partial frame is lost.
- Index wrap never occurs: the range check guarantees idx ≤ NUM_WORDS-1.

## Structure
- config_loader_pkg holds: state enum (IDLE, LOAD, SETUP, STROBE, HOLD, DONE), header field LSB/MSB constants, and the IDX_W derivation function.
- One sub-module, cfg_onehot_dec (index → NUM_WORDS one-hot, plus an enable input). Its output is registered in config_loader.
- The latch bank is instantiated by the tile, not inside this block.

## Test plan
- Full load, default params: header S=0,C=29, then 30 words 0xA000_0000+i with valid held → each enable bit i fires for 1 cycle with io_d_in=0xA000_0000+i. Enable is always preceded by one SETUP cycle and followed by one HOLD cycle. io_done pulses 4 cycles after the last accept plus one.
- Partial load: header S=27,C=2, words 0x1,0x2,0x3 → en[27],en[28],en[29] fire in order. io_err=0, no other bit toggles.
- Range error: header S=28,C=2 (N=3) → io_err=1, no enables, state IDLE. The next valid header S=0,C=0 clears io_err.
- Backpressure/bubbles: valid toggled randomly, data changes only after acceptance → each word appears on io_d_in exactly once and en is one-hot or zero every cycle.
- Reset at the STROBE cycle of word 2 of 5 → en=0 and all outputs are at reset values the next cycle. A following full frame completes normally.
- STROBE_CYCLES=3: single-word frame → enable high for exactly 3 consecutive cycles, 6 cycles from payload accept to the last HOLD.

Source files
------------

// File: rtl/config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_loader_pkg
// Brief    : Shared state encoding, header field helpers and index-width
//            derivation for the tile configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
package config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int C_HDR_START_LSB = 0;

    // Never narrower than one bit, so single-word banks still get a legal index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int hdr_start_msb(input int idx_w);
        return idx_w - 1;
    endfunction

    function automatic int hdr_count_lsb(input int idx_w);
        return idx_w;
    endfunction

    function automatic int hdr_count_msb(input int idx_w);
        return 2 * idx_w - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : cfg_onehot_dec
// Brief    : Word index to one-hot latch enable decoder with a global enable.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_onehot_dec #(
    parameter int NUM_WORDS = 30,
    parameter int IDX_W     = 5
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 en,
    output logic [NUM_WORDS-1:0] onehot
);

    genvar i;
    generate
        for (i = 0; i < NUM_WORDS; i++) begin : g_bit
            assign onehot[i] = en && (idx == IDX_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Brief    : Framed word stream to latch bank sequencer (setup/strobe/hold).
// Revision : 1.0 - initial release
// ============================================================================
module config_loader
    import config_loader_pkg::*;
#(
    parameter int NUM_WORDS     = 30,
    parameter int WORD_W        = 32,
    parameter int STROBE_CYCLES = 1,
    parameter int IDX_W         = idx_width(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_cfg_valid,
    input  logic [WORD_W-1:0]    io_cfg_data,
    output logic                 io_cfg_ready,
    output logic [WORD_W-1:0]    io_d_in,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_err
);

    localparam int CNT_W   = IDX_W + 1;
    localparam int SCNT_W  = idx_width(STROBE_CYCLES);
    localparam int C_S_MSB = hdr_start_msb(IDX_W);
    localparam int C_C_LSB = hdr_count_lsb(IDX_W);
    localparam int C_C_MSB = hdr_count_msb(IDX_W);

    localparam logic [CNT_W-1:0]  C_NUM_WORDS   = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0]  C_ONE         = CNT_W'(1);
    localparam logic [SCNT_W-1:0] C_STROBE_LAST = SCNT_W'(STROBE_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_rem;
    logic [SCNT_W-1:0]    r_scnt;
    logic [WORD_W-1:0]    r_d_in;
    logic [NUM_WORDS-1:0] r_en;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_accept;
    logic [IDX_W-1:0]     w_hdr_start;
    logic [IDX_W-1:0]     w_hdr_cnt_m1;
    logic [CNT_W-1:0]     w_hdr_n;
    logic [CNT_W-1:0]     w_hdr_end;
    logic                 w_hdr_bad;
    logic                 w_strobe_next;
    logic [NUM_WORDS-1:0] w_onehot;

    assign w_accept     = io_cfg_valid && r_ready;
    assign w_hdr_start  = io_cfg_data[C_S_MSB:C_HDR_START_LSB];
    assign w_hdr_cnt_m1 = io_cfg_data[C_C_MSB:C_C_LSB];
    // One extra bit keeps start + count free of overflow for any header.
    assign w_hdr_n      = {1'b0, w_hdr_cnt_m1} + C_ONE;
    assign w_hdr_end    = {1'b0, w_hdr_start} + w_hdr_n;
    assign w_hdr_bad    = (w_hdr_end > C_NUM_WORDS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept && !w_hdr_bad) w_next = ST_LOAD;
            ST_LOAD:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_STROBE;
            ST_STROBE: if (r_scnt == C_STROBE_LAST) w_next = ST_HOLD;
            ST_HOLD:   w_next = (r_rem == C_ONE) ? ST_DONE : ST_LOAD;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_strobe_next = (w_next == ST_STROBE);

    cfg_onehot_dec #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_dec (
        .idx    (r_idx),
        .en     (w_strobe_next),
        .onehot (w_onehot)
    );

    // Outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_scnt  <= '0;
            r_d_in  <= '0;
            r_en    <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= w_onehot;
            r_ready <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_err <= w_hdr_bad;
                        r_idx <= w_hdr_start;
                        r_rem <= w_hdr_n;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) r_d_in <= io_cfg_data;
                end
                ST_SETUP: begin
                    r_scnt <= '0;
                end
                ST_STROBE: begin
                    r_scnt <= r_scnt + SCNT_W'(1);
                end
                ST_HOLD: begin
                    r_rem <= r_rem - C_ONE;
                    if (r_rem != C_ONE) r_idx <= r_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign io_cfg_ready  = r_ready;
    assign io_d_in       = r_d_in;
    assign io_configs_en = r_en;
    assign io_busy       = r_busy;
    assign io_done       = r_done;
    assign io_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Brief    : Scoreboard bench for config_loader (default and 3-cycle strobe).
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    localparam int NW = 30;
    localparam int WW = 32;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [WW-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic [WW-1:0] d_in;
    logic [NW-1:0] en;
    logic          busy, done, err;

    logic          v3 = 1'b0;
    logic [WW-1:0] dat3 = '0;
    logic          rdy3;
    logic [WW-1:0] din3;
    logic [NW-1:0] en3;
    logic          busy3, done3, err3;

    int  n_checks = 0;
    int  n_fails  = 0;
    bit  mon_on   = 1'b0;
    ev_t q[$];

    always #5 clk = ~clk;

    config_loader dut (
        .clk (clk), .reset (reset),
        .io_cfg_valid (cfg_valid), .io_cfg_data (cfg_data), .io_cfg_ready (cfg_ready),
        .io_d_in (d_in), .io_configs_en (en), .io_busy (busy), .io_done (done), .io_err (err)
    );

    config_loader #(.STROBE_CYCLES(3)) dut3 (
        .clk (clk), .reset (reset),
        .io_cfg_valid (v3), .io_cfg_data (dat3), .io_cfg_ready (rdy3),
        .io_d_in (din3), .io_configs_en (en3), .io_busy (busy3), .io_done (done3), .io_err (err3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Unused header bits are set so the bench also shows they are ignored.
    function automatic logic [31:0] hdr(input int s, input int c);
        return 32'hF0F0_0000 | 32'((c << 5) | s);
    endfunction

    task automatic send(input logic [WW-1:0] d);
        int t = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        while (!cfg_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic run_frame(input int s, input int c, input logic [31:0] base, input bit bubbles);
        ev_t e;
        send(hdr(s, c));
        chk("err_clear", err, 0);
        for (int i = 0; i <= c; i++) begin
            e.kind = K_WR; e.idx = s + i; e.data = base + 32'(i);
            q.push_back(e);
            if (i == c) begin
                e.kind = K_DONE; e.idx = 0; e.data = '0;
                q.push_back(e);
            end
            if (bubbles) repeat ($urandom_range(0, 3)) @(negedge clk);
            send(base + 32'(i));
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_d_in"}, d_in, 0);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Monitor: pops the scoreboard whenever a strobe starts or done pulses.
    logic [NW-1:0] prev_en = '0;
    logic [WW-1:0] prev_d  = '0;
    int            width   = 0;
    ev_t           mev;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("en_onehot0", 64'($onehot0(en)), 1);
            if (en != 0 && prev_en == 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", en, 0);
                end else begin
                    mev = q.pop_front();
                    chk("strobe_kind", mev.kind, K_WR);
                    chk("strobe_en", en, 64'(1) << mev.idx);
                    chk("strobe_data", d_in, mev.data);
                    chk("setup_data", prev_d, d_in);
                end
                width = 1;
            end else if (en != 0) begin
                width++;
                chk("strobe_stable", en, prev_en);
                chk("data_stable", d_in, prev_d);
            end else if (prev_en != 0) begin
                chk("strobe_width", width, 1);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    mev = q.pop_front();
                    chk("done_kind", mev.kind, K_DONE);
                end
            end
            prev_en = en;
            prev_d  = d_in;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int hi;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cfg_ready, 1);
        mon_on = 1'b1;

        // Full load with valid held continuously, then done timing.
        run_frame(0, 29, 32'hA000_0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("done_early", done, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("done_end", done, 0);
        chk("busy_end", busy, 0);

        // Partial load touching the top of the bank.
        run_frame(27, 2, 32'h0000_0001, 1'b0);
        wait_idle();
        chk("partial_err", err, 0);

        // Range errors: frame rejected, controller stays idle.
        send(hdr(28, 2));
        chk("range_err", err, 1);
        chk("range_busy", busy, 0);
        chk("range_en", en, 0);
        send(hdr(0, 31));
        chk("range_err32", err, 1);
        chk("range_busy32", busy, 0);
        run_frame(0, 0, 32'h0000_0055, 1'b0);
        wait_idle();

        // Random bubbles on the upstream valid.
        run_frame(10, 4, 32'h0000_0100, 1'b1);
        wait_idle();
        run_frame(29, 0, 32'h0000_0777, 1'b1);
        wait_idle();

        // Reset during the strobe of the second word of five.
        begin
            ev_t e;
            send(hdr(3, 4));
            for (int i = 0; i < 2; i++) begin
                e.kind = K_WR; e.idx = 3 + i; e.data = 32'hB0 + 32'(i);
                q.push_back(e);
                send(32'hB0 + 32'(i));
            end
        end
        t = 0;
        while (en == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_strobe_en", en, 64'(1) << 4);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        run_frame(0, 29, 32'hC000_0000, 1'b0);
        wait_idle();
        chk("sb_empty", q.size(), 0);

        // Three-cycle strobe, single-word frame at index 5.
        v3 = 1'b1;
        dat3 = hdr(5, 0);
        t = 0;
        while (!rdy3 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        dat3 = 32'hDEAD_BEEF;
        t = 0;
        while (!rdy3 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        v3 = 1'b0;
        t = 0;
        hi = 0;
        while (!done3 && t < 40) begin
            if (en3 != 0) begin
                hi++;
                chk("s3_en", en3, 64'(1) << 5);
                chk("s3_data", din3, 32'hDEAD_BEEF);
            end
            @(negedge clk);
            t++;
        end
        chk("s3_width", hi, 3);
        chk("s3_done_lat", t, 5);
        @(negedge clk);
        chk("s3_busy_end", busy3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
